// File: rtl/jt49_pkg.sv
// jt49_pkg: register map and envelope shape bit positions shared by the envelope blocks.
package jt49_pkg;
    localparam logic [3:0] ENV_FINE   = 4'hB;
    localparam logic [3:0] ENV_COARSE = 4'hC;
    localparam logic [3:0] ENV_SHAPE  = 4'hD;
    localparam int CONT = 3;
    localparam int ATT  = 2;
    localparam int ALT  = 1;
    localparam int HOLD = 0;
endpackage

// File: rtl/jt49_env_presc.sv
// jt49_env_presc: cen-gated prescaler, tick marks the last cen pulse of each 2**W cycle.
module jt49_env_presc #(
    parameter int W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic clr,
    output logic tick
);
    logic [W-1:0] cnt_q;

    assign tick = cen && &cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else if (cen) cnt_q <= cnt_q + 1'b1;
    end
endmodule

// File: rtl/jt49_env_timer.sv
// jt49_env_timer: envelope period/shape registers and the step generator feeding the envelope.
module jt49_env_timer
    import jt49_pkg::*;
#(
    parameter int         PRESC_W     = 3,
    parameter logic [3:0] ADDR_FINE   = ENV_FINE,
    parameter logic [3:0] ADDR_COARSE = ENV_COARSE,
    parameter logic [3:0] ADDR_SHAPE  = ENV_SHAPE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr,
    input  logic [3:0]  addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic [15:0] period,
    output logic [3:0]  ctrl,
    output logic        step,
    output logic        null_period,
    output logic        restart
);
    logic [15:0] period_q, period_d, cnt_q, cnt_d;
    logic [16:0] cnt_inc;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  dout_q, dout_d;
    logic        step_q, step_d, null_q, restart_q, tick, shape_wr;

    assign shape_wr = wr && addr == ADDR_SHAPE;
    // 17-bit sum keeps cnt=65535 from wrapping below the period
    assign cnt_inc  = {1'b0, cnt_q} + 17'd1;

    jt49_env_presc #(.W(PRESC_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .clr  (shape_wr),
        .tick (tick)
    );

    always_comb begin
        period_d = period_q;
        if (wr && addr == ADDR_FINE) period_d[7:0] = din;
        if (wr && addr == ADDR_COARSE) period_d[15:8] = din;
        ctrl_d = shape_wr ? din[3:0] : ctrl_q;
        dout_d = addr == ADDR_FINE   ? period_q[7:0]  :
                 addr == ADDR_COARSE ? period_q[15:8] :
                 addr == ADDR_SHAPE  ? {4'b0, ctrl_q} : 8'd0;
        cnt_d  = cnt_q;
        step_d = step_q;
        if (shape_wr) begin
            cnt_d  = '0;
            step_d = 1'b0;
        end else if (tick) begin
            cnt_d  = (period_q == 16'd0 || cnt_inc >= {1'b0, period_q}) ? 16'd0 : cnt_inc[15:0];
            step_d = period_q == 16'd0 ? 1'b0 : cnt_inc >= {1'b0, period_q} ? !step_q : step_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= '0;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            dout_q    <= '0;
            step_q    <= 1'b0;
            null_q    <= 1'b1;
            restart_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            dout_q    <= dout_d;
            step_q    <= step_d;
            null_q    <= period_d == 16'd0;
            restart_q <= shape_wr;
        end
    end

    assign period      = period_q;
    assign ctrl        = ctrl_q;
    assign dout        = dout_q;
    assign step        = step_q;
    assign null_period = null_q;
    assign restart     = restart_q;
endmodule

// File: tb/tb_jt49_env_timer.sv
// tb_jt49_env_timer: directed checks of register writes, step timing, shape restart and reset.
module tb_jt49_env_timer;
    localparam logic [3:0] FINE = 4'hB, COARSE = 4'hC, SHAPE = 4'hD;

    logic        clk = 0, rst = 1, cen = 1, wr = 0;
    logic [3:0]  addr = 0;
    logic [7:0]  din = 0;
    logic [7:0]  dout;
    logic [15:0] period;
    logic [3:0]  ctrl;
    logic        step, null_period, restart;
    int          errors = 0, checks = 0;

    jt49_env_timer dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .wr          (wr),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .period      (period),
        .ctrl        (ctrl),
        .step        (step),
        .null_period (null_period),
        .restart     (restart)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        wr = 1; addr = a; din = d;
        cyc(1);
        wr = 0;
    endtask

    task automatic wait_toggle(input int max, output int n);
        logic prev;
        prev = step;
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            cyc(1);
            if (step !== prev) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1; cyc(2); rst = 0;
        checks++;
        if (period !== 16'h0 || ctrl !== 4'h0 || dout !== 8'h0 || step !== 1'b0 || restart !== 1'b0 || null_period !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got period=%h ctrl=%h dout=%h step=%b restart=%b null=%b, want 0000 0 00 0 0 1",
                     period, ctrl, dout, step, restart, null_period);
        end
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            checks++;
            if (period !== 16'h0 || step !== 1'b0 || restart !== 1'b0 || null_period !== 1'b1) begin
                errors++;
                $display("FAIL idle_cycle_%0d: got period=%h step=%b restart=%b null=%b, want 0000 0 0 1",
                         i, period, step, restart, null_period);
            end
        end
    endtask

    task automatic test_basic;
        int n;
        wr_reg(FINE, 8'h02);
        checks++;
        if (null_period !== 1'b0 || period !== 16'h0002) begin
            errors++;
            $display("FAIL fine_write: got period=%h null=%b, want 0002 0", period, null_period);
        end
        wr_reg(COARSE, 8'h00);
        wait_toggle(40, n);
        for (int k = 0; k < 2; k++) begin
            wait_toggle(40, n);
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL step_interval_%0d: got %0d cycles, want 16", k, n);
            end
        end
    endtask

    task automatic test_shape;
        int n;
        wr_reg(SHAPE, 8'hF5);
        checks++;
        if (ctrl !== 4'h5 || restart !== 1'b1) begin
            errors++;
            $display("FAIL shape_hi_nibble: got ctrl=%h restart=%b, want 5 1", ctrl, restart);
        end
        cyc(1);
        checks++;
        if (restart !== 1'b0) begin
            errors++;
            $display("FAIL restart_one_cycle: got restart=%b, want 0", restart);
        end
        cyc(5);
        wr_reg(SHAPE, 8'h0E);
        checks++;
        if (ctrl !== 4'hE || restart !== 1'b1 || step !== 1'b0) begin
            errors++;
            $display("FAIL shape_write: got ctrl=%h restart=%b step=%b, want e 1 0", ctrl, restart, step);
        end
        wait_toggle(40, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL shape_first_toggle: got %0d cycles, want 16", n);
        end
    endtask

    task automatic test_reduce;
        int n;
        wr_reg(SHAPE, 8'h0E);
        wr_reg(FINE, 8'h00);
        wr_reg(COARSE, 8'h01);
        cyc(1022);
        wr_reg(FINE, 8'h10);
        wr_reg(COARSE, 8'h00);
        cyc(5);
        checks++;
        if (step !== 1'b0 || period !== 16'h0010) begin
            errors++;
            $display("FAIL reduce_before_tick: got step=%b period=%h, want 0 0010", step, period);
        end
        cyc(1);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL reduce_wrap_toggle: got step=%b, want 1", step);
        end
        wait_toggle(200, n);
        checks++;
        if (n !== 128) begin
            errors++;
            $display("FAIL reduce_next_interval: got %0d cycles, want 128", n);
        end
    endtask

    task automatic test_shape_on_tick;
        wr_reg(SHAPE, 8'h0E);
        wr_reg(FINE, 8'h01);
        wr_reg(COARSE, 8'h00);
        cyc(5);
        checks++;
        if (step !== 1'b0) begin
            errors++;
            $display("FAIL p1_pre: got step=%b, want 0", step);
        end
        cyc(1);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL p1_first_tick: got step=%b, want 1", step);
        end
        cyc(15);
        wr_reg(SHAPE, 8'h0E);
        checks++;
        if (step !== 1'b0 || restart !== 1'b1) begin
            errors++;
            $display("FAIL shape_on_tick: got step=%b restart=%b, want 0 1", step, restart);
        end
        cyc(7);
        checks++;
        if (step !== 1'b0) begin
            errors++;
            $display("FAIL shape_on_tick_hold: got step=%b, want 0", step);
        end
        cyc(1);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL shape_on_tick_resume: got step=%b, want 1", step);
        end
    endtask

    task automatic test_readback;
        wr_reg(COARSE, 8'h5A);
        addr = COARSE; cyc(1);
        checks++;
        if (dout !== 8'h5A) begin
            errors++;
            $display("FAIL read_coarse: got %h, want 5a", dout);
        end
        addr = FINE; cyc(1);
        checks++;
        if (dout !== 8'h01) begin
            errors++;
            $display("FAIL read_fine: got %h, want 01", dout);
        end
        addr = SHAPE; cyc(1);
        checks++;
        if (dout !== 8'h0E) begin
            errors++;
            $display("FAIL read_shape: got %h, want 0e", dout);
        end
        addr = 4'h3; cyc(1);
        checks++;
        if (dout !== 8'h00) begin
            errors++;
            $display("FAIL read_other: got %h, want 00", dout);
        end
        wr_reg(COARSE, 8'h00);
    endtask

    task automatic test_cen;
        int t[$];
        logic prev;
        wr_reg(SHAPE, 8'h0E);
        prev = step;
        for (int i = 0; i < 200; i++) begin
            cen = (i % 3 == 0);
            cyc(1);
            if (step !== prev) t.push_back(i);
            prev = step;
        end
        cen = 1;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (t.size() < 4 || t[k+1] - t[k] !== 24) begin
                errors++;
                $display("FAIL cen_interval_%0d: got %0d toggles, interval %0d, want 24",
                         k, t.size(), t.size() >= 4 ? t[k+1] - t[k] : -1);
            end
        end
    endtask

    task automatic test_rst_mid;
        wr_reg(SHAPE, 8'h0A);
        cyc(9);
        rst = 1; wr = 1; addr = FINE; din = 8'h55;
        cyc(1);
        rst = 0; wr = 0;
        checks++;
        if (period !== 16'h0 || ctrl !== 4'h0 || dout !== 8'h0 || step !== 1'b0 || restart !== 1'b0 || null_period !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid: got period=%h ctrl=%h dout=%h step=%b restart=%b null=%b, want 0000 0 00 0 0 1",
                     period, ctrl, dout, step, restart, null_period);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_shape;
        test_reduce;
        test_shape_on_tick;
        test_readback;
        test_cen;
        test_rst_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
